// File: rtl/fpu_pkg.sv
// Shared FP types for the decoder/issue path: FPU op encodings, RV32F major opcodes, issue FSM states.
// Also defines the fflags bit layout {NV,DZ,OF,UF,NX} used by the sticky accumulator.
package fpu_pkg;

    typedef enum logic [3:0] {
        FMADD    = 4'd0,
        FNMSUB   = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        DIV      = 4'd4,
        SQRT     = 4'd5,
        SGNJ     = 4'd6,
        MINMAX   = 4'd7,
        CMP      = 4'd8,
        CLASSIFY = 4'd9,
        F2F      = 4'd10,
        F2I      = 4'd11,
        I2F      = 4'd12,
        CPKAB    = 4'd13,
        CPKCD    = 4'd14
    } fp_operations_e;

    typedef enum logic [6:0] {
        OPC_LOAD_FP  = 7'b0000111,
        OPC_STORE_FP = 7'b0100111,
        OPC_FMADD    = 7'b1000011,
        OPC_FMSUB    = 7'b1000111,
        OPC_FNMSUB   = 7'b1001011,
        OPC_FNMADD   = 7'b1001111,
        OPC_OP_FP    = 7'b1010011
    } fp_opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } issue_state_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_FP   = 2'd1,
        DST_INT  = 2'd2
    } dst_e;

    localparam int FFLAGS_W = 5;
    localparam int FFLAG_NX = 0;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_NV = 4;

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request/response channel between the issue controller (master) and the FPU core (slave).
// Request and response each use valid/ready; fpu_flush_o is a one-cycle kill toward the FPU.
interface fpu_issue_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              fpu_in_valid_o;
    logic              fpu_in_ready_i;
    logic [3:0]        fpu_op_o;
    logic              fpu_op_mod_o;
    logic [2:0]        fpu_rnd_o;
    logic [DATA_W-1:0] fpu_opa_o;
    logic [DATA_W-1:0] fpu_opb_o;
    logic [DATA_W-1:0] fpu_opc_o;
    logic              fpu_out_valid_i;
    logic              fpu_out_ready_o;
    logic [DATA_W-1:0] fpu_result_i;
    logic [4:0]        fpu_status_i;
    logic              fpu_flush_o;

    modport master (
        output fpu_in_valid_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_o,
               fpu_opa_o, fpu_opb_o, fpu_opc_o, fpu_out_ready_o, fpu_flush_o,
        input  fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i
    );

    modport slave (
        input  fpu_in_valid_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_o,
               fpu_opa_o, fpu_opb_o, fpu_opc_o, fpu_out_ready_o, fpu_flush_o,
        output fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i
    );
endinterface

// File: rtl/fpu_fflags_reg.sv
// Sticky fflags accumulator, single-cycle update; no backpressure.
// A clear in the same cycle as an accumulate leaves only the new status.
module fpu_fflags_reg
    import fpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                acc_en,
    input  logic [FFLAGS_W-1:0] status,
    output logic [FFLAGS_W-1:0] fflags
);

    logic [FFLAGS_W-1:0] base;

    assign base = clr ? '0 : fflags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags <= '0;
        end else if (clr || acc_en) begin
            fflags <= acc_en ? (base | status) : base;
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP issue stage: 3 cycles + FPU latency from fpu_enable_i to writeback; stalls upstream in ISSUE/WAIT, waits on FPU valid/ready.
// Optional FPU_ISSUE_TIMEOUT_EN bounds WAIT to TIMEOUT_CYCLES and flags a sticky timeout_err_o.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
`ifdef FPU_ISSUE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fpu_enable_i,
    input  logic [4:0]        apu_op_i,
    input  logic [2:0]        fp_rnd_mode_i,
    input  logic              rf_float_en_i,
    input  logic              rf_int_en_i,
    input  logic [DATA_W-1:0] rs1_i,
    input  logic [DATA_W-1:0] rs2_i,
    input  logic [DATA_W-1:0] rs3_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic              flush_i,
    input  logic              fflags_clr_i,
    output logic              stall_o,
    output logic              fp_wr_en_o,
    output logic              int_wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [4:0]        fflags_o,
    output logic              busy_o,
`ifdef FPU_ISSUE_TIMEOUT_EN
    output logic              timeout_err_o,
`endif
    fpu_issue_ctrl_if.master  fpu
);

    issue_state_e      state_q, state_d;
    logic [3:0]        op_q;
    logic              op_mod_q;
    logic [2:0]        rnd_q;
    logic [DATA_W-1:0] opa_q, opb_q, opc_q, result_q;
    logic [ADDR_W-1:0] rd_q;
    dst_e              dst_q;
    logic              kill_q;
    logic [4:0]        status_q;

    logic              in_valid, out_ready, flush_out, wr_ok;

`ifdef FPU_ISSUE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0]  cnt_q;
    logic              timeout;
    logic              timeout_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_o   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush_out = 1'b0;
`ifdef FPU_ISSUE_TIMEOUT_EN
        timeout   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                stall_o = fpu_enable_i;
                if (fpu_enable_i && !flush_i) state_d = ISSUE;
            end
            ISSUE: begin
                stall_o  = 1'b1;
                in_valid = 1'b1;
                // An accepted op must be drained even if flushed in the same cycle
                if (fpu.fpu_in_ready_i)  state_d = WAIT;
                else if (flush_i)        state_d = IDLE;
            end
            WAIT: begin
                stall_o   = 1'b1;
                out_ready = 1'b1;
                flush_out = flush_i;
                if (fpu.fpu_out_valid_i) begin
                    state_d = WB;
`ifdef FPU_ISSUE_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout   = 1'b1;
                    flush_out = 1'b1;
                    state_d   = IDLE;
`endif
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            op_mod_q <= 1'b0;
            rnd_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            opc_q    <= '0;
            rd_q     <= '0;
            dst_q    <= DST_NONE;
            kill_q   <= 1'b0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fpu_enable_i && !flush_i) begin
                        op_q     <= apu_op_i[3:0];
                        op_mod_q <= apu_op_i[4];
                        rnd_q    <= fp_rnd_mode_i;
                        opa_q    <= rs1_i;
                        opb_q    <= rs2_i;
                        opc_q    <= rs3_i;
                        rd_q     <= rd_i;
                        dst_q    <= rf_float_en_i ? DST_FP : (rf_int_en_i ? DST_INT : DST_NONE);
                        kill_q   <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (fpu.fpu_in_ready_i && flush_i) kill_q <= 1'b1;
                end
                WAIT: begin
                    kill_q <= kill_q | flush_i;
                    if (fpu.fpu_out_valid_i) begin
                        result_q <= fpu.fpu_result_i;
                        status_q <= fpu.fpu_status_i;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FPU_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
            timeout_err_q <= timeout_err_q | timeout;
        end
    end

    assign timeout_err_o = timeout_err_q;
`endif

    assign wr_ok       = (state_q == WB) && !kill_q;
    assign fp_wr_en_o  = wr_ok && (dst_q == DST_FP);
    assign int_wr_en_o = wr_ok && (dst_q == DST_INT);
    assign wr_addr_o   = rd_q;
    assign wr_data_o   = result_q;
    assign busy_o      = (state_q != IDLE);

    assign fpu.fpu_in_valid_o  = in_valid;
    assign fpu.fpu_out_ready_o = out_ready;
    assign fpu.fpu_flush_o     = flush_out;
    assign fpu.fpu_op_o        = op_q;
    assign fpu.fpu_op_mod_o    = op_mod_q;
    assign fpu.fpu_rnd_o       = rnd_q;
    assign fpu.fpu_opa_o       = opa_q;
    assign fpu.fpu_opb_o       = opb_q;
    assign fpu.fpu_opc_o       = opc_q;

    fpu_fflags_reg u_fflags (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (fflags_clr_i),
        .acc_en (wr_ok),
        .status (status_q),
        .fflags (fflags_o)
    );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Random + directed bench for fpu_issue_ctrl: the bench plays decoder and FPU, expected writebacks
// are queued at issue and popped by an independent monitor; fflags follow a simple OR/clear model.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              fpu_enable_i = 1'b0;
    logic [4:0]        apu_op_i = '0;
    logic [2:0]        fp_rnd_mode_i = '0;
    logic              rf_float_en_i = 1'b0;
    logic              rf_int_en_i = 1'b0;
    logic [DATA_W-1:0] rs1_i = '0, rs2_i = '0, rs3_i = '0;
    logic [ADDR_W-1:0] rd_i = '0;
    logic              flush_i = 1'b0;
    logic              fflags_clr_i = 1'b0;
    logic              stall_o, fp_wr_en_o, int_wr_en_o, busy_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic [4:0]        fflags_o;
`ifdef FPU_ISSUE_TIMEOUT_EN
    logic              timeout_err;
`endif

    fpu_issue_ctrl_if #(.DATA_W(DATA_W)) fpu ();

    fpu_issue_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fpu_enable_i  (fpu_enable_i),
        .apu_op_i      (apu_op_i),
        .fp_rnd_mode_i (fp_rnd_mode_i),
        .rf_float_en_i (rf_float_en_i),
        .rf_int_en_i   (rf_int_en_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .rs3_i         (rs3_i),
        .rd_i          (rd_i),
        .flush_i       (flush_i),
        .fflags_clr_i  (fflags_clr_i),
        .stall_o       (stall_o),
        .fp_wr_en_o    (fp_wr_en_o),
        .int_wr_en_o   (int_wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .fflags_o      (fflags_o),
        .busy_o        (busy_o),
`ifdef FPU_ISSUE_TIMEOUT_EN
        .timeout_err_o (timeout_err),
`endif
        .fpu           (fpu)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_fp;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [4:0] ff_model = '0;
    int         total = 0;
    int         bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Writeback monitor: every write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && (fp_wr_en_o || int_wr_en_o)) begin
            if (fp_wr_en_o && int_wr_en_o) begin
                check("wr_both_pulsed", 32'd1, 32'd0);
            end else if (exp_q.size() == 0) begin
                check("unexpected_write", {30'd0, fp_wr_en_o, int_wr_en_o}, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_kind_fp", 32'(fp_wr_en_o), 32'(e.is_fp));
                check("wr_addr", 32'(wr_addr_o), 32'(e.addr));
                check("wr_data", wr_data_o, e.data);
            end
        end
    end

    task automatic init_fpu();
        fpu.fpu_in_ready_i  = 1'b0;
        fpu.fpu_out_valid_i = 1'b0;
        fpu.fpu_result_i    = '0;
        fpu.fpu_status_i    = '0;
    endtask

    task automatic scramble();
        apu_op_i      = 5'($urandom);
        fp_rnd_mode_i = 3'($urandom);
        rs1_i         = $urandom;
        rs2_i         = $urandom;
        rs3_i         = $urandom;
        rd_i          = 5'($urandom);
        rf_float_en_i = 1'($urandom);
        rf_int_en_i   = 1'($urandom);
    endtask

    // mode: 0 normal, 1 flush in ISSUE before accept, 2 flush with accept, 3 flush in WAIT
    task automatic do_op(input logic [4:0] apu, input logic [2:0] rnd, input logic fe, input logic ie,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [4:0] rd, input int ilat, input int rlat,
                         input logic [31:0] res, input logic [4:0] st, input int mode, input logic clr);
        logic killed;
        wr_t  e;
        killed = (mode != 0);
        if (!killed && (fe || ie)) begin
            e.is_fp = fe;
            e.addr  = rd;
            e.data  = res;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        fpu_enable_i = 1'b1; apu_op_i = apu; fp_rnd_mode_i = rnd;
        rf_float_en_i = fe; rf_int_en_i = ie;
        rs1_i = a; rs2_i = b; rs3_i = c; rd_i = rd;
        flush_i = 1'b0; fflags_clr_i = 1'b0;
        @(negedge clk);
        check("idle_stall", 32'(stall_o), 32'd1);
        check("idle_busy", 32'(busy_o), 32'd0);
        for (int i = 0; i <= ilat; i++) begin
            @(posedge clk); #1;
            scramble();
            if (i == ilat) begin
                if (mode == 1) flush_i = 1'b1;
                else begin
                    fpu.fpu_in_ready_i = 1'b1;
                    flush_i = (mode == 2);
                end
            end
            @(negedge clk);
            check("issue_valid", 32'(fpu.fpu_in_valid_o), 32'd1);
            check("issue_stall", 32'(stall_o), 32'd1);
            check("issue_op", {27'd0, fpu.fpu_op_mod_o, fpu.fpu_op_o}, {27'd0, apu});
            check("issue_rnd", 32'(fpu.fpu_rnd_o), 32'(rnd));
            check("issue_opa", fpu.fpu_opa_o, a);
            check("issue_opb", fpu.fpu_opb_o, b);
            check("issue_opc", fpu.fpu_opc_o, c);
        end
        if (mode == 1) begin
            @(posedge clk); #1;
            flush_i = 1'b0; fpu_enable_i = 1'b0;
            @(negedge clk);
            check("abort_busy", 32'(busy_o), 32'd0);
            check("abort_valid", 32'(fpu.fpu_in_valid_o), 32'd0);
            check("abort_fflags", 32'(fflags_o), 32'(ff_model));
            return;
        end
        for (int i = 0; i < rlat; i++) begin
            @(posedge clk); #1;
            fpu.fpu_in_ready_i = 1'b0;
            flush_i = (mode == 3) && (i == 0);
            fpu.fpu_result_i = $urandom;
            fpu.fpu_status_i = 5'($urandom);
            @(negedge clk);
            check("wait_out_ready", 32'(fpu.fpu_out_ready_o), 32'd1);
            check("wait_in_valid", 32'(fpu.fpu_in_valid_o), 32'd0);
            check("wait_stall", 32'(stall_o), 32'd1);
            check("wait_fpu_flush", 32'(fpu.fpu_flush_o), 32'((mode == 3) && (i == 0)));
        end
        @(posedge clk); #1;
        fpu.fpu_in_ready_i  = 1'b0;
        fpu.fpu_out_valid_i = 1'b1;
        fpu.fpu_result_i    = res;
        fpu.fpu_status_i    = st;
        flush_i = (mode == 3) && (rlat == 0);
        @(negedge clk);
        check("capture_out_ready", 32'(fpu.fpu_out_ready_o), 32'd1);
        @(posedge clk); #1;
        fpu.fpu_out_valid_i = 1'b0;
        fpu.fpu_result_i    = $urandom;
        flush_i = 1'b0;
        fflags_clr_i = clr;
        @(negedge clk);
        check("wb_stall", 32'(stall_o), 32'd0);
        check("wb_busy", 32'(busy_o), 32'd1);
        if (clr) ff_model = killed ? 5'd0 : st;
        else if (!killed) ff_model = ff_model | st;
        @(posedge clk); #1;
        fpu_enable_i = 1'b0; fflags_clr_i = 1'b0;
        @(negedge clk);
        check("post_busy", 32'(busy_o), 32'd0);
        check("post_fflags", 32'(fflags_o), 32'(ff_model));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, 32'(stall_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_in_valid"}, 32'(fpu.fpu_in_valid_o), 32'd0);
        check({tag, "_out_ready"}, 32'(fpu.fpu_out_ready_o), 32'd0);
        check({tag, "_fpu_flush"}, 32'(fpu.fpu_flush_o), 32'd0);
        check({tag, "_wr_en"}, {30'd0, fp_wr_en_o, int_wr_en_o}, 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
        check({tag, "_wr_data"}, wr_data_o, 32'd0);
        check({tag, "_fflags"}, 32'(fflags_o), 32'd0);
        check({tag, "_opa"}, fpu.fpu_opa_o, 32'd0);
        check({tag, "_op"}, 32'(fpu.fpu_op_o), 32'd0);
    endtask

    initial begin
        logic [4:0] st;
        int         mode;
        init_fpu();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_op({1'b0, ADD}, 3'b000, 1'b1, 1'b0, 32'h3FC00000, 32'h40100000, 32'h0, 5'd3,
              2, 2, 32'h40700000, 5'b00000, 0, 1'b0);
        do_op({1'b0, CMP}, 3'b010, 1'b0, 1'b1, 32'h3F800000, 32'h3F800000, 32'h0, 5'd5,
              0, 1, 32'h00000001, 5'b00000, 0, 1'b0);
        do_op({1'b0, MUL}, 3'b000, 1'b1, 1'b0, 32'h40000000, 32'h40000000, 32'h0, 5'd7,
              1, 3, 32'hDEADBEEF, 5'b10000, 3, 1'b0);
        check("flush_fflags_kept", 32'(fflags_o), 32'd0);
        do_op({1'b0, DIV}, 3'b001, 1'b1, 1'b0, $urandom, $urandom, 32'h0, 5'd9,
              0, 4, $urandom, 5'b00001, 0, 1'b0);
        st = 5'(1 << FFLAG_NV);
        do_op({1'b0, SQRT}, 3'b000, 1'b0, 1'b0, $urandom, 32'h0, 32'h0, 5'd1,
              1, 0, $urandom, st, 0, 1'b0);
        check("fflags_accum", 32'(fflags_o), 32'h11);
        do_op({1'b1, FMADD}, 3'b100, 1'b1, 1'b0, $urandom, $urandom, $urandom, 5'd12,
              0, 2, $urandom, 5'b00100, 0, 1'b1);
        check("fflags_clr_with_wb", 32'(fflags_o), 32'h04);
        do_op({1'b0, F2I}, 3'b001, 1'b0, 1'b1, 32'h4B000000, 32'h0, 32'h0, 5'd20,
              10, 1, 32'h00800000, 5'b00001, 0, 1'b0);

        // Reset asserted while the FPU is still working on an op
        @(posedge clk); #1;
        fpu_enable_i = 1'b1; rf_float_en_i = 1'b1; rf_int_en_i = 1'b0;
        apu_op_i = 5'(ADD); rs1_i = $urandom; rd_i = 5'd4;
        @(posedge clk); #1;
        fpu.fpu_in_ready_i = 1'b1;
        @(posedge clk); #1;
        fpu.fpu_in_ready_i = 1'b0;
        @(negedge clk);
        check("pre_reset_wait", 32'(fpu.fpu_out_ready_o), 32'd1);
        #2;
        rst_n = 1'b0; fpu_enable_i = 1'b0;
        #1;
        check_all_zero("midreset");
        ff_model = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 150; n++) begin
            mode = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            do_op(5'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                  $urandom, $urandom, $urandom, 5'($urandom),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                  $urandom, 5'($urandom), mode, ($urandom_range(0, 4) == 0));
        end

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
